load_store_ctrl: RTL and testbench
==================================

Name: load_store_ctrl

Overview:
Multi-cycle load/store sequencer between the execute stage and the data memory. It accepts one request at a time and handshakes with a variable-latency memory. For stores it generates byte strobes and lane-replicated write data. For loads it aligns the returned word and sign/zero-extends it per funct3.

Parameters:
BUS_SIZE, 32, data/address width (fixed at 32; byte lanes = 4)
TIMEOUT_CYC, 16, consecutive mem_busy cycles before an access is aborted

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a load/store
req_ready  out  1  controller can accept a request (IDLE)
req_store  in  1  1 = store, 0 = load
funct3  in  3  RV32 width/sign code
addr  in  32  byte address
wdata  in  32  store data (low bits significant)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte-enable mask
mem_rdata  in  32  memory read word
mem_busy  in  1  memory not ready; hold strobe
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  extended load result (0 for stores/errors)
resp_err  out  1  timeout abort, qualified by resp_valid
misalign  out  1  misaligned access, qualified by resp_valid
stall  out  1  pipeline freeze, = (state != IDLE)

Behaviour:
- Reset: state IDLE; mem_read, mem_write, mem_wstrb, resp_valid, resp_data, resp_err, misalign = 0; req_ready = 1. Asynchronous reset mid-access drops strobes immediately. The in-flight request is lost and no response is given.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: req_ready = 1. When req_valid = 1, latch req_store, funct3, addr, wdata and go to ACCESS.
- ACCESS: assert mem_read (load) or mem_write (store), holding address/data/strobes stable.
  - The access completes in the first cycle with mem_busy = 0. Load data is sampled from mem_rdata in that cycle. Go to RESP.
  - While mem_busy = 1, increment the timeout counter. When it reaches TIMEOUT_CYC, deassert the strobe, set resp_err and go to RESP.
  - The counter clears on entry to ACCESS.
- RESP: resp_valid = 1 for exactly one cycle; req_ready = 0. Return to IDLE.
  - A request is never accepted in RESP.
  - Back-to-back requests are accepted in the following IDLE cycle.
- Latency: request accepted in cycle 0, strobe in cycle 1, resp_valid in cycle 2 + N, where N = busy cycles.
- Outputs outside ACCESS: mem_read, mem_write and mem_wstrb are 0.
- Store lane generation (off = addr[1:0]):
  - funct3 000: mem_wstrb = 4'b0001 << off; mem_wdata = wdata[7:0] replicated x4.
  - funct3 001: mem_wstrb = 4'b0011 << {off[1],1'b0}; mem_wdata = wdata[15:0] replicated x2.
  - Otherwise: mem_wstrb = 4'b1111; mem_wdata = wdata.
- Load alignment and extension: shifted = mem_rdata >> 8*off (half-words use {off[1],0}; words use 0).
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half-word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half-word.
  - Any other funct3: full word.
- resp_data is registered and held until the next RESP. It is forced to 0 on stores and on resp_err.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- With the macro: a half-word access with addr[0] = 1, or a word access with addr[1:0] != 0, skips ACCESS. The controller goes IDLE -> RESP with misalign = 1, resp_data = 0, and no memory strobe.
- Without the macro: misalign is tied to 0. Low address bits are truncated as described above and the access proceeds.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - the state typedef (IDLE/ACCESS/RESP)
  - BUS_SIZE
- Sub-module load_align_ext: a purely combinational shift plus extension. It takes the memory word, offset and funct3 and produces the 32-bit result. It is instantiated once.

Test Plan:
1. lb, addr 0x103, mem_rdata 0x80FF_1234, mem_busy 0 -> mem_addr 0x100, mem_read in cycle 1, resp_valid in cycle 2, resp_data 0xFFFF_FF80.
2. lhu, addr 0x102, mem_rdata 0x8001_0000 -> resp_data 0x0000_8001; lh at the same address -> 0xFFFF_8001.
3. sb, addr 0x201, wdata 0x0000_00AB -> mem_write = 1, mem_addr 0x200, mem_wstrb 4'b0010, mem_wdata 0xABAB_ABAB, resp_data 0.
4. lw, mem_busy = 1 for 3 cycles -> mem_read held 4 cycles, resp_valid in cycle 5, stall = 1 in cycles 1..5.
5. mem_busy stuck at 1 -> strobe drops after 16 busy cycles; resp_valid with resp_err = 1 and resp_data 0; next request accepted normally.
6. With LSU_MISALIGN_TRAP_EN: lw at 0x102 -> no mem_read, misalign = 1 in cycle 1. Separately, rst_n low during ACCESS -> mem_read = 0 immediately and req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    localparam int BUS_SIZE = 32;
    localparam int LANES    = BUS_SIZE / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Size is taken from funct3[1:0]: 00 byte, 01 half, anything else a word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        if (f3[1:0] == 2'b00) begin
            mis = 1'b0;
        end else if (f3[1:0] == 2'b01) begin
            mis = off[0];
        end else begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load-path alignment: shifts the addressed byte/half-word down to bit 0 and
// sign- or zero-extends it according to funct3.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [BUS_SIZE-1:0] word,
    input  logic [1:0]          off,
    input  logic [2:0]          funct3,
    output logic [BUS_SIZE-1:0] result
);

    logic [1:0]          lane;
    logic [BUS_SIZE-1:0] shifted;

    always_comb begin
        lane = 2'b00;
        if (funct3[1:0] == 2'b00) begin
            lane = off;
        end else if (funct3[1:0] == 2'b01) begin
            lane = {off[1], 1'b0};
        end
        shifted = word >> {lane, 3'b000};
    end

    always_comb begin
        result = shifted;
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  result = {24'd0, shifted[7:0]};
            F3_LHU:  result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Multi-cycle load/store sequencer between the execute stage and data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          funct3,
    input  logic [BUS_SIZE-1:0] addr,
    input  logic [BUS_SIZE-1:0] wdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BUS_SIZE-1:0] mem_addr,
    output logic [BUS_SIZE-1:0] mem_wdata,
    output logic [LANES-1:0]    mem_wstrb,
    input  logic [BUS_SIZE-1:0] mem_rdata,
    input  logic                mem_busy,
    output logic                resp_valid,
    output logic [BUS_SIZE-1:0] resp_data,
    output logic                resp_err,
    output logic                misalign,
    output logic                stall
);

    // state  | meaning
    // IDLE   | ready, latches the next request
    // ACCESS | strobe held until mem_busy drops or the timeout expires
    // RESP   | one-cycle completion pulse, never accepts

    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYC - 1);

    lsu_state_e          state, state_nxt;
    logic                store_q;
    logic [2:0]          f3_q;
    logic [BUS_SIZE-1:0] addr_q;
    logic [BUS_SIZE-1:0] wdata_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                err_q;
    logic                mis_q;
    logic [BUS_SIZE-1:0] rdata_q;
    logic [BUS_SIZE-1:0] load_ext;
    logic [LANES-1:0]    lane_strb;
    logic [BUS_SIZE-1:0] lane_wdata;
    logic                accept;
    logic                access_done;
    logic                access_tmo;
    logic                req_mis;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = is_misaligned(funct3, addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        access_done = 1'b0;
        access_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_busy) begin
                    access_done = 1'b1;
                    state_nxt   = RESP;
                end else if (tmo_cnt == '0) begin
                    access_tmo = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Timeout is a down-counter: reaching zero while still busy marks the last allowed busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
                tmo_cnt <= TMO_INIT;
                err_q   <= 1'b0;
                mis_q   <= req_mis;
                if (req_mis) begin
                    rdata_q <= '0;
                end
            end
            if (state == ACCESS && mem_busy && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (access_done) begin
                rdata_q <= store_q ? '0 : load_ext;
            end
            if (access_tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    load_align_ext u_align (
        .word   (mem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .result (load_ext)
    );

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata_q;
        case (f3_q)
            F3_LB: begin
                lane_strb  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            F3_LH: begin
                lane_strb  = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign stall      = (state != IDLE);
    assign mem_read   = (state == ACCESS) && !store_q;
    assign mem_write  = (state == ACCESS) && store_q;
    assign mem_addr   = {addr_q[BUS_SIZE-1:2], 2'b00};
    assign mem_wdata  = lane_wdata;
    assign mem_wstrb  = mem_write ? lane_strb : '0;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign misalign   = resp_valid && mis_q;
    assign resp_data  = rdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed scenarios plus randomized
// transactions compared against a behavioural model of the access rules.
module tb_load_store_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_busy = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        misalign;
    logic        stall;

    int tests = 0;
    int failed = 0;

    int          o_strobe, o_rd, o_wr, o_first, o_resp, o_stall;
    logic [31:0] o_addr, o_wdata, o_data, o_after_data;
    logic [3:0]  o_strb;
    logic        o_err, o_mis, o_unstable, o_stray, o_ready_req, o_ready_resp;
    logic        o_after_valid, o_after_ready;

    load_store_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_busy   (mem_busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .misalign   (misalign),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int s;
        case (f3)
            3'b000:  s = 1 << int'(a[1:0]);
            3'b001:  s = 3 << (2 * int'(a[1]));
            default: s = 15;
        endcase
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return (wd & 32'hFF) * 32'h0101_0101;
            3'b001:  return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        int size;
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        return (a % size) != 0;
`else
        return (f3 == 3'd7) && (a == 32'd1) && 1'b0;
`endif
    endfunction

    // Drives one request from a negedge in IDLE and records what the DUT does, cycle by cycle.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int busy);
        req_valid = 1'b1; req_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_busy = 1'b0; mem_rdata = $urandom;
        o_ready_req = req_ready;
        o_strobe = 0; o_rd = 0; o_wr = 0; o_first = -1; o_resp = -1; o_stall = 0;
        o_unstable = 1'b0; o_stray = 1'b0; o_addr = '0; o_strb = '0; o_wdata = '0;
        o_data = '0; o_err = 1'b0; o_mis = 1'b0; o_ready_resp = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            mem_busy  = (c <= busy);
            mem_rdata = (c == busy + 1) ? rd : $urandom;
            if (mem_read || mem_write) begin
                if (o_first < 0) begin
                    o_first = c; o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata;
                end else if (mem_addr !== o_addr || mem_wstrb !== o_strb || mem_wdata !== o_wdata) begin
                    o_unstable = 1'b1;
                end
                o_strobe++;
                if (mem_read) o_rd++;
                if (mem_write) o_wr++;
            end
            if ((mem_wstrb != 4'd0 && !mem_write) || (mem_read && mem_write)) o_stray = 1'b1;
            if (stall) o_stall++;
            if (resp_valid) begin
                o_resp = c; o_data = resp_data; o_err = resp_err; o_mis = misalign;
                o_ready_resp = req_ready;
                break;
            end
            @(negedge clk);
        end
        mem_busy = 1'b0;
        @(negedge clk);
        o_after_valid = resp_valid; o_after_ready = req_ready; o_after_data = resp_data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({mem_read, mem_write, mem_wstrb} !== 6'd0) begin failed++; $display("FAIL reset_strobes: got %b want 000000", {mem_read, mem_write, mem_wstrb}); end
        tests++; if ({resp_valid, resp_err, misalign, stall} !== 4'd0) begin failed++; $display("FAIL reset_resp_flags: got %b want 0000", {resp_valid, resp_err, misalign, stall}); end
        tests++; if (resp_data !== 32'd0) begin failed++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_ext;
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
        tests++; if (o_first !== 1 || o_rd !== 1) begin failed++; $display("FAIL lb_strobe: first %0d count %0d want 1 1", o_first, o_rd); end
        tests++; if (o_addr !== 32'h100) begin failed++; $display("FAIL lb_addr: got %h want 00000100", o_addr); end
        tests++; if (o_resp !== 2) begin failed++; $display("FAIL lb_resp_cycle: got %0d want 2", o_resp); end
        tests++; if (o_data !== 32'hFFFF_FF80) begin failed++; $display("FAIL lb_data: got %h want ffffff80", o_data); end
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 0);
        tests++; if (o_data !== 32'h0000_8001) begin failed++; $display("FAIL lhu_data: got %h want 00008001", o_data); end
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0);
        tests++; if (o_data !== 32'hFFFF_8001) begin failed++; $display("FAIL lh_data: got %h want ffff8001", o_data); end
        tests++; if (o_after_data !== 32'hFFFF_8001) begin failed++; $display("FAIL lh_data_held: got %h want ffff8001", o_after_data); end
    endtask

    task automatic test_store_lanes;
        run_txn(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h5555_5555, 0);
        tests++; if (o_wr !== 1 || o_rd !== 0) begin failed++; $display("FAIL sb_write: wr %0d rd %0d want 1 0", o_wr, o_rd); end
        tests++; if (o_addr !== 32'h200) begin failed++; $display("FAIL sb_addr: got %h want 00000200", o_addr); end
        tests++; if (o_strb !== 4'b0010) begin failed++; $display("FAIL sb_wstrb: got %b want 0010", o_strb); end
        tests++; if (o_wdata !== 32'hABAB_ABAB) begin failed++; $display("FAIL sb_wdata: got %h want abababab", o_wdata); end
        tests++; if (o_data !== 32'd0) begin failed++; $display("FAIL sb_resp_data: got %h want 0", o_data); end
    endtask

    task automatic test_busy_latency;
        run_txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h1357_9BDF, 3);
        tests++; if (o_rd !== 4) begin failed++; $display("FAIL busy_strobe_len: got %0d want 4", o_rd); end
        tests++; if (o_resp !== 5) begin failed++; $display("FAIL busy_resp_cycle: got %0d want 5", o_resp); end
        tests++; if (o_stall !== 5) begin failed++; $display("FAIL busy_stall_len: got %0d want 5", o_stall); end
        tests++; if (o_data !== 32'h1357_9BDF) begin failed++; $display("FAIL busy_data: got %h want 13579bdf", o_data); end
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'hFFFF_FFFF, 100);
        tests++; if (o_rd !== TMO) begin failed++; $display("FAIL tmo_strobe_len: got %0d want %0d", o_rd, TMO); end
        tests++; if (o_resp !== TMO + 1) begin failed++; $display("FAIL tmo_resp_cycle: got %0d want %0d", o_resp, TMO + 1); end
        tests++; if (o_err !== 1'b1 || o_data !== 32'd0) begin failed++; $display("FAIL tmo_err_data: err %b data %h want 1 0", o_err, o_data); end
        run_txn(1'b0, 3'b010, 32'h84, 32'h0, 32'h2468_ACE0, TMO - 1);
        tests++; if (o_err !== 1'b0 || o_data !== 32'h2468_ACE0 || o_resp !== TMO + 1) begin failed++; $display("FAIL tmo_edge_no_err: err %b data %h cycle %0d", o_err, o_data, o_resp); end
        run_txn(1'b0, 3'b100, 32'h7, 32'h0, 32'hA500_0000, 0);
        tests++; if (o_ready_req !== 1'b1 || o_resp !== 2 || o_err !== 1'b0 || o_data !== 32'hA5) begin failed++; $display("FAIL tmo_recover: ready %b cycle %0d err %b data %h", o_ready_req, o_resp, o_err, o_data); end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0);
        tests++; if (o_strobe !== 0) begin failed++; $display("FAIL mis_no_strobe: got %0d want 0", o_strobe); end
        tests++; if (o_resp !== 1 || o_mis !== 1'b1) begin failed++; $display("FAIL mis_resp: cycle %0d mis %b want 1 1", o_resp, o_mis); end
        tests++; if (o_data !== 32'd0) begin failed++; $display("FAIL mis_data: got %h want 0", o_data); end
        run_txn(1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 0);
        tests++; if (o_strobe !== 0 || o_mis !== 1'b1) begin failed++; $display("FAIL mis_sh: strobes %0d mis %b want 0 1", o_strobe, o_mis); end
`else
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0);
        tests++; if (o_mis !== 1'b0 || o_resp !== 2) begin failed++; $display("FAIL nomis_resp: mis %b cycle %0d want 0 2", o_mis, o_resp); end
        tests++; if (o_addr !== 32'h100 || o_data !== 32'hCAFE_F00D) begin failed++; $display("FAIL nomis_trunc: addr %h data %h", o_addr, o_data); end
`endif
    endtask

    task automatic test_async_reset;
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h300; mem_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests++; if (mem_read !== 1'b1) begin failed++; $display("FAIL arst_pre_read: got %b want 1", mem_read); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (mem_read !== 1'b0 || stall !== 1'b0) begin failed++; $display("FAIL arst_drop: read %b stall %b want 0 0", mem_read, stall); end
        @(negedge clk);
        rst_n = 1'b1; mem_busy = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL arst_ready: got %b want 1", req_ready); end
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                if (resp_valid || mem_read || mem_write) seen++;
                @(negedge clk);
            end
            tests++; if (seen !== 0) begin failed++; $display("FAIL arst_no_resp: activity %0d want 0", seen); end
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_store = 1'b1; funct3 = 3'b010; addr = 32'h340; wdata = 32'hDEAD_BEEF;
        mem_busy = 1'b0;
        @(negedge clk);
        req_store = 1'b0; funct3 = 3'b100; addr = 32'h455; wdata = 32'h0;
        tests++; if (mem_write !== 1'b1 || mem_addr !== 32'h340 || mem_wdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL b2b_first_access: wr %b addr %h wdata %h", mem_write, mem_addr, mem_wdata); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== 32'd0) begin failed++; $display("FAIL b2b_first_resp: valid %b ready %b data %h", resp_valid, req_ready, resp_data); end
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failed++; $display("FAIL b2b_idle: ready %b valid %b want 1 0", req_ready, resp_valid); end
        @(negedge clk);
        req_valid = 1'b0; mem_rdata = 32'h1122_3344;
        tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h454) begin failed++; $display("FAIL b2b_second_access: rd %b addr %h want 1 00000454", mem_read, mem_addr); end
        @(negedge clk);
        mem_rdata = $urandom;
        tests++; if (resp_valid !== 1'b1 || resp_data !== 32'h33) begin failed++; $display("FAIL b2b_second_resp: valid %b data %h want 1 00000033", resp_valid, resp_data); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [2:0]  f3_tab [8];
        logic        st, e_mis, e_tmo;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, e_data;
        int          busy, r, e_str, e_resp;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom);
            f3 = f3_tab[$urandom_range(0, 7)];
            a  = $urandom; wd = $urandom; rd = $urandom;
            r  = $urandom_range(0, 9);
            busy = (r < 7) ? r % 4 : ((r == 7) ? TMO - 1 : ((r == 8) ? TMO : TMO + 4));
            e_mis  = ref_mis(f3, a);
            e_tmo  = !e_mis && busy >= TMO;
            e_str  = e_mis ? 0 : (e_tmo ? TMO : busy + 1);
            e_resp = e_mis ? 1 : (e_tmo ? TMO + 1 : busy + 2);
            e_data = (st || e_mis || e_tmo) ? 32'd0 : ref_load(f3, a, rd);
            run_txn(st, f3, a, wd, rd, busy);
            tests++; if (o_ready_req !== 1'b1) begin failed++; $display("FAIL rnd%0d ready: got %b want 1", i, o_ready_req); end
            tests++; if (o_resp !== e_resp) begin failed++; $display("FAIL rnd%0d resp_cycle: got %0d want %0d", i, o_resp, e_resp); end
            tests++; if ((st ? o_wr : o_rd) !== e_str || o_strobe !== e_str) begin failed++; $display("FAIL rnd%0d strobes: rd %0d wr %0d want %0d st %b", i, o_rd, o_wr, e_str, st); end
            if (e_str > 0) begin
                tests++; if (o_addr !== (a & 32'hFFFF_FFFC)) begin failed++; $display("FAIL rnd%0d addr: got %h want %h", i, o_addr, a & 32'hFFFF_FFFC); end
            end
            if (st && e_str > 0) begin
                tests++; if (o_strb !== ref_strb(f3, a)) begin failed++; $display("FAIL rnd%0d wstrb: got %b want %b", i, o_strb, ref_strb(f3, a)); end
                tests++; if (o_wdata !== ref_wdata(f3, wd)) begin failed++; $display("FAIL rnd%0d wdata: got %h want %h", i, o_wdata, ref_wdata(f3, wd)); end
            end
            tests++; if (o_data !== e_data) begin failed++; $display("FAIL rnd%0d data: got %h want %h f3 %0d a %h", i, o_data, e_data, f3, a); end
            tests++; if (o_err !== e_tmo || o_mis !== e_mis) begin failed++; $display("FAIL rnd%0d flags: err %b mis %b want %b %b", i, o_err, o_mis, e_tmo, e_mis); end
            tests++; if (o_stall !== e_resp) begin failed++; $display("FAIL rnd%0d stall_len: got %0d want %0d", i, o_stall, e_resp); end
            tests++; if (o_unstable !== 1'b0 || o_stray !== 1'b0) begin failed++; $display("FAIL rnd%0d bus_hygiene: unstable %b stray %b want 0 0", i, o_unstable, o_stray); end
            tests++; if (o_ready_resp !== 1'b0 || o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin failed++; $display("FAIL rnd%0d handshake: resp_ready %b after_valid %b after_ready %b", i, o_ready_resp, o_after_valid, o_after_ready); end
            tests++; if (o_after_data !== e_data) begin failed++; $display("FAIL rnd%0d data_held: got %h want %h", i, o_after_data, e_data); end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_lanes();
        test_busy_latency();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
